compute_accel: RTL and testbench

- Parametrised memory-mapped reduction engine. Successor to the fixed 8-entry summing slave.
- Holds DEPTH operand registers of DATA_W bits.
- On a start command, walks the first COUNT operands one per clock and produces SUM, MIN, MAX or XOR. Done, overflow and parity flags are reported through a status register.
- Sits on the same chip-select/read/write slave bus as the other system peripherals.

---
 rtl/compute_accel.sv | 235 +++++++++++++++++++++++
 tb/tb_compute_accel.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/compute_accel.sv
// Memory-mapped reduction engine: DEPTH operand registers reduced by SUM/MIN/MAX/XOR.
// Optional interrupt output enabled by defining COMPUTE_ACCEL_IRQ_EN.
module compute_accel #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH) + 1
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iChipSelect_n,
    input  logic              iWrite_n,
    input  logic              iRead_n,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [31:0]       iData,
`ifdef COMPUTE_ACCEL_IRQ_EN
    output logic              oIrq,
`endif
    output logic [31:0]       oData
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(DEPTH + 1);
    localparam logic [ADDR_W-1:0] ADDR_RESULT = ADDR_W'(DEPTH + 2);
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = ADDR_W'(DEPTH + 3);
    localparam logic [1:0] MODE_SUM = 2'b00;
    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;
    localparam logic [1:0] MODE_XOR = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} stateT;

    stateT              stateR, stateNxt;
    logic [DATA_W-1:0]  opReg [DEPTH];
    logic [DATA_W-1:0]  accR, accNxt, resultR, opCur, wrVal;
    logic [DATA_W:0]    sumExt;
    logic [ADDR_W-1:0]  countR, countWr, idxR;
    logic [1:0]         modeR;
    logic               ovfR, evenR, doneR, doneNxt, carry;
    logic               wrEn, rdEn, idle, wrAccept, isOpAddr, startReq, ctrlIrqBit;
    logic [IDX_W-1:0]   opIdx;
    logic [31:0]        readVal;
    logic               unusedBits;

    assign wrEn       = ~iChipSelect_n & ~iWrite_n;
    assign rdEn       = ~iChipSelect_n & ~iRead_n;
    assign idle       = (stateR == IDLE);
    assign wrAccept   = wrEn & idle;
    assign isOpAddr   = ~iAddress[ADDR_W-1];
    assign opIdx      = iAddress[IDX_W-1:0];
    assign startReq   = wrAccept & (iAddress == ADDR_CTRL) & iData[0];
    assign wrVal      = iData[DATA_W-1:0];
    assign opCur      = opReg[idxR[IDX_W-1:0]];
    assign unusedBits = ^iData;

    // FSM state register
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            stateR <= IDLE;
        end else begin
            stateR <= stateNxt;
        end
    end

    // FSM next-state: RUN ends once element COUNT-1 has been consumed
    always_comb begin
        stateNxt = stateR;
        case (stateR)
            IDLE: begin
                if (startReq) begin
                    stateNxt = (countR == ADDR_W'(1)) ? FINISH : RUN;
                end else begin
                    stateNxt = IDLE;
                end
            end
            RUN: begin
                if (idxR == countR - ADDR_W'(1)) begin
                    stateNxt = FINISH;
                end else begin
                    stateNxt = RUN;
                end
            end
            FINISH:  stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Reduction operator applied to accumulator and current operand
    always_comb begin
        sumExt = {1'b0, accR} + {1'b0, opCur};
        carry  = 1'b0;
        case (modeR)
            MODE_SUM: begin
                accNxt = sumExt[DATA_W-1:0];
                carry  = sumExt[DATA_W];
            end
            MODE_MIN: accNxt = (opCur < accR) ? opCur : accR;
            MODE_MAX: accNxt = (opCur > accR) ? opCur : accR;
            MODE_XOR: accNxt = accR ^ opCur;
            default:  accNxt = accR;
        endcase
    end

    // COUNT write clamping into 1..DEPTH
    always_comb begin
        if (wrVal == DATA_W'(0)) begin
            countWr = ADDR_W'(1);
        end else if (wrVal > DATA_W'(DEPTH)) begin
            countWr = ADDR_W'(DEPTH);
        end else begin
            countWr = wrVal[ADDR_W-1:0];
        end
    end

    // done: set by FINISH (wins), cleared by accepted start or STATUS read
    always_comb begin
        if (stateR == FINISH) begin
            doneNxt = 1'b1;
        end else if (startReq) begin
            doneNxt = 1'b0;
        end else if (rdEn && (iAddress == ADDR_STATUS)) begin
            doneNxt = 1'b0;
        end else begin
            doneNxt = doneR;
        end
    end

    // Operand register file, writable only while idle
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int i = 0; i < DEPTH; i++) opReg[i] <= '0;
        end else if (wrAccept && isOpAddr) begin
            opReg[opIdx] <= wrVal;
        end
    end

    // COUNT and mode configuration
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            countR <= ADDR_W'(DEPTH);
            modeR  <= MODE_SUM;
        end else begin
            if (wrAccept && (iAddress == ADDR_COUNT)) countR <= countWr;
            if (startReq) modeR <= iData[2:1];
        end
    end

    // Accumulator, index, result and flags
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            accR    <= '0;
            idxR    <= '0;
            resultR <= '0;
            ovfR    <= 1'b0;
            evenR   <= 1'b0;
            doneR   <= 1'b0;
        end else begin
            case (stateR)
                IDLE: begin
                    if (startReq) begin
                        accR  <= opReg[0];
                        idxR  <= ADDR_W'(1);
                        ovfR  <= 1'b0;
                        evenR <= 1'b0;
                    end
                end
                RUN: begin
                    accR <= accNxt;
                    idxR <= idxR + ADDR_W'(1);
                    ovfR <= ovfR | carry;
                end
                FINISH: begin
                    resultR <= accR;
                    evenR   <= ~accR[0];
                end
                default: accR <= accR;
            endcase
            doneR <= doneNxt;
        end
    end

`ifdef COMPUTE_ACCEL_IRQ_EN
    logic irqEnR, irqEnNxt;

    assign ctrlIrqBit = irqEnR;

    // Interrupt enable next value
    always_comb begin
        if (wrAccept && (iAddress == ADDR_CTRL)) begin
            irqEnNxt = iData[3];
        end else begin
            irqEnNxt = irqEnR;
        end
    end

    // Interrupt enable and registered interrupt, tracking done
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            irqEnR <= 1'b0;
            oIrq   <= 1'b0;
        end else begin
            irqEnR <= irqEnNxt;
            oIrq   <= doneNxt & irqEnNxt;
        end
    end
`else
    assign ctrlIrqBit = 1'b0;
`endif

    // Read mux, sampled from pre-edge state so same-cycle writes are not visible
    always_comb begin
        readVal = 32'd0;
        if (isOpAddr) begin
            readVal = 32'(opReg[opIdx]);
        end else begin
            case (iAddress)
                ADDR_CTRL:   readVal = {28'd0, ctrlIrqBit, modeR, 1'b0};
                ADDR_STATUS: readVal = {28'd0, evenR, ovfR, doneR, ~idle};
                ADDR_RESULT: readVal = 32'(resultR);
                ADDR_COUNT:  readVal = 32'(countR);
                default:     readVal = 32'd0;
            endcase
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oData <= 32'd0;
        end else if (rdEn) begin
            oData <= readVal;
        end else begin
            oData <= oData;
        end
    end
endmodule

// File: tb/tb_compute_accel.sv
// Directed self-checking bench for compute_accel (DATA_W=32, DEPTH=8).
module tb_compute_accel;
    localparam int ADDR_W = 4;
    localparam logic [ADDR_W-1:0] A_CTRL   = 4'd8;
    localparam logic [ADDR_W-1:0] A_STATUS = 4'd9;
    localparam logic [ADDR_W-1:0] A_RESULT = 4'd10;
    localparam logic [ADDR_W-1:0] A_COUNT  = 4'd11;

    logic              iClk = 1'b0;
    logic              iReset_n = 1'b0;
    logic              iChipSelect_n = 1'b1;
    logic              iWrite_n = 1'b1;
    logic              iRead_n = 1'b1;
    logic [ADDR_W-1:0] iAddress = '0;
    logic [31:0]       iData = 32'd0;
    logic [31:0]       oData;
`ifdef COMPUTE_ACCEL_IRQ_EN
    logic              oIrq;
`endif
    int totalCnt = 0;
    int badCnt = 0;

    compute_accel #(.DATA_W(32), .DEPTH(8)) dut (
        .iClk(iClk), .iReset_n(iReset_n), .iChipSelect_n(iChipSelect_n),
        .iWrite_n(iWrite_n), .iRead_n(iRead_n), .iAddress(iAddress),
        .iData(iData),
`ifdef COMPUTE_ACCEL_IRQ_EN
        .oIrq(oIrq),
`endif
        .oData(oData)
    );

    always #5 iClk = ~iClk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All bus tasks start at a falling edge and end at the next one
    task automatic busWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        iChipSelect_n = 1'b0; iWrite_n = 1'b0; iRead_n = 1'b1; iAddress = a; iData = d;
        @(negedge iClk);
        iChipSelect_n = 1'b1; iWrite_n = 1'b1;
    endtask

    task automatic busRead(input logic [ADDR_W-1:0] a, output logic [31:0] d);
        iChipSelect_n = 1'b0; iWrite_n = 1'b1; iRead_n = 1'b0; iAddress = a;
        @(negedge iClk);
        d = oData;
        iChipSelect_n = 1'b1; iRead_n = 1'b1;
    endtask

    task automatic busRW(input logic [ADDR_W-1:0] a, input logic [31:0] wd, output logic [31:0] rd);
        iChipSelect_n = 1'b0; iWrite_n = 1'b0; iRead_n = 1'b0; iAddress = a; iData = wd;
        @(negedge iClk);
        rd = oData;
        iChipSelect_n = 1'b1; iWrite_n = 1'b1; iRead_n = 1'b1;
    endtask

    task automatic loadOps(input logic [31:0] v0, v1, v2, v3, v4, v5, v6, v7);
        logic [31:0] v [8];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < 8; i++) busWrite(ADDR_W'(i), v[i]);
    endtask

    task automatic runOp(input logic [31:0] ctrl, output logic [31:0] status, output logic [31:0] result);
        logic [31:0] s;
        bit seen;
        seen = 1'b0;
        s = 32'd0;
        busWrite(A_CTRL, ctrl);
        for (int k = 0; k < 40 && !seen; k++) begin
            busRead(A_STATUS, s);
            if (s[1]) seen = 1'b1;
        end
        checkValue("done_timeout", {31'd0, seen}, 32'd1);
        status = s;
        busRead(A_RESULT, result);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, s;
        int doneCnt;
        repeat (2) @(negedge iClk);
        checkValue("rst_odata", oData, 32'd0);
        iReset_n = 1'b1;
        busRead(A_STATUS, r); checkValue("rst_status", r, 32'd0);
        busRead(A_COUNT, r);  checkValue("rst_count", r, 32'd8);
        busRead(A_RESULT, r); checkValue("rst_result", r, 32'd0);
        busRead(A_CTRL, r);   checkValue("rst_ctrl", r, 32'd0);

        // SUM 1..8 with cycle-exact done
        loadOps(1, 2, 3, 4, 5, 6, 7, 8);
        busWrite(A_COUNT, 32'd8);
        busWrite(A_CTRL, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            busRead(A_STATUS, r);
            checkValue($sformatf("sum_busy_%0d", k), r & 32'h3, 32'h1);
        end
        busRead(A_STATUS, r); checkValue("sum_status_done", r, 32'hA);
        busRead(A_STATUS, r); checkValue("sum_status_again", r, 32'h8);
        busRead(A_RESULT, r); checkValue("sum_result", r, 32'd36);

        // MIN / MAX / XOR
        loadOps(5, 3, 9, 1, 7, 2, 8, 4);
        runOp(32'h3, s, r);   checkValue("min_result", r, 32'd1);
        busRead(A_CTRL, r);   checkValue("min_ctrl", r, 32'h2);
        runOp(32'h5, s, r);   checkValue("max_result", r, 32'd9);
        busRead(A_CTRL, r);   checkValue("max_ctrl", r, 32'h4);
        runOp(32'h7, s, r);   checkValue("xor8_result", r, 32'h7);
        busWrite(A_COUNT, 32'd7);
        runOp(32'h7, s, r);   checkValue("xor7_result", r, 32'h3);
        busWrite(A_COUNT, 32'd1);
        runOp(32'h3, s, r);   checkValue("cnt1_result", r, 32'd5);
        checkValue("cnt1_status", s, 32'h2);

        // Overflow and COUNT clamping
        busWrite(4'd0, 32'hFFFF_FFFF);
        busWrite(4'd1, 32'hFFFF_FFFF);
        busWrite(A_COUNT, 32'd2);
        runOp(32'h1, s, r);
        checkValue("ovf_result", r, 32'hFFFF_FFFE);
        checkValue("ovf_status", s, 32'hE);
        busWrite(A_COUNT, 32'd0);   busRead(A_COUNT, r); checkValue("count_zero", r, 32'd1);
        busWrite(A_COUNT, 32'd100); busRead(A_COUNT, r); checkValue("count_big", r, 32'd8);
        busWrite(A_COUNT, 32'd5);   busRead(A_COUNT, r); checkValue("count_mid", r, 32'd5);
        busRead(4'd13, r); checkValue("unmapped_read", r, 32'd0);

        // Same-cycle read and write
        busWrite(4'd2, 32'h11);
        busRW(4'd2, 32'h22, r); checkValue("rw_pre_value", r, 32'h11);
        busRead(4'd2, r);       checkValue("rw_post_value", r, 32'h22);

        // Writes ignored while busy; single done pulse
        loadOps(1, 2, 3, 4, 5, 6, 7, 8);
        busWrite(A_COUNT, 32'd8);
        busWrite(A_CTRL, 32'h1);
        busWrite(4'd3, 32'hDEAD);
        busWrite(A_CTRL, 32'h1);
        busWrite(A_COUNT, 32'd2);
        busRead(A_RESULT, r); checkValue("busy_old_result", r, 32'hFFFF_FFFE);
        doneCnt = 0;
        for (int k = 0; k < 20; k++) begin
            busRead(A_STATUS, r);
            if (r[1]) doneCnt++;
        end
        checkValue("busy_done_pulses", 32'(doneCnt), 32'd1);
        busRead(A_RESULT, r); checkValue("busy_result", r, 32'd36);
        busRead(4'd3, r);     checkValue("busy_op3", r, 32'd4);
        busRead(A_COUNT, r);  checkValue("busy_count", r, 32'd8);

        // Asynchronous reset mid-run
        busRead(4'd7, r); checkValue("pre_rst_op7", r, 32'd8);
        busWrite(A_CTRL, 32'h1);
        repeat (3) @(negedge iClk);
        #2 iReset_n = 1'b0;
        #1 checkValue("midrun_rst_odata", oData, 32'd0);
        @(negedge iClk);
        iReset_n = 1'b1;
        busRead(A_STATUS, r); checkValue("midrun_status", r, 32'd0);
        busRead(A_RESULT, r); checkValue("midrun_result", r, 32'd0);
        busRead(A_COUNT, r);  checkValue("midrun_count", r, 32'd8);
        busRead(4'd0, r);     checkValue("midrun_op0", r, 32'd0);
        loadOps(1, 2, 3, 4, 5, 6, 7, 8);
        runOp(32'h1, s, r);   checkValue("post_rst_sum", r, 32'd36);

`ifdef COMPUTE_ACCEL_IRQ_EN
        busWrite(A_CTRL, 32'h9);
        repeat (7) @(negedge iClk);
        checkValue("irq_before_done", {31'd0, oIrq}, 32'd0);
        @(negedge iClk);
        checkValue("irq_with_done", {31'd0, oIrq}, 32'd1);
        busRead(A_CTRL, r);   checkValue("irq_ctrl", r, 32'h8);
        busRead(A_STATUS, r); checkValue("irq_status", r & 32'h2, 32'h2);
        checkValue("irq_cleared", {31'd0, oIrq}, 32'd0);
        busWrite(A_CTRL, 32'h1);
        repeat (10) @(negedge iClk);
        checkValue("irq_disabled", {31'd0, oIrq}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end
endmodule
